dmem_sram_arbiter: RTL and testbench

DMEM_SRAM_ARBITER -- requirements
Module: dmem_sram_arbiter

---
 rtl/dmem_sram_arbiter_if.sv | 43 ++++
 rtl/dmem_sram_arbiter.sv | 96 +++++++++
 tb/tb_dmem_sram_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_sram_arbiter_if.sv
// dmem_sram_arbiter_if: core, programmer and SRAM macro signal bundle for the arbiter
interface dmem_sram_arbiter_if #(
  parameter int AddrW = 13,
  parameter int DataW = 32
);
  logic             a_csb_i;
  logic             a_we_i;
  logic [AddrW-1:0] a_addr_i;
  logic [DataW-1:0] a_wdata_i;
  logic [3:0]       a_wmask_i;
  logic [DataW-1:0] a_rdata_o;
  logic             b_req_i;
  logic             b_we_i;
  logic [AddrW-1:0] b_addr_i;
  logic [DataW-1:0] b_wdata_i;
  logic [3:0]       b_wmask_i;
  logic             b_gnt_o;
  logic             b_rvalid_o;
  logic [DataW-1:0] b_rdata_o;
  logic             sram_csb_o;
  logic             sram_web_o;
  logic [AddrW-1:0] sram_addr_o;
  logic [DataW-1:0] sram_wdata_o;
  logic [3:0]       sram_wmask_o;
  logic [DataW-1:0] sram_rdata_i;
  logic             init_done_o;
  modport slave (
    input  a_csb_i, a_we_i, a_addr_i, a_wdata_i, a_wmask_i,
    input  b_req_i, b_we_i, b_addr_i, b_wdata_i, b_wmask_i,
    input  sram_rdata_i,
    output a_rdata_o, b_gnt_o, b_rvalid_o, b_rdata_o,
    output sram_csb_o, sram_web_o, sram_addr_o, sram_wdata_o, sram_wmask_o,
    output init_done_o
  );
  modport master (
    output a_csb_i, a_we_i, a_addr_i, a_wdata_i, a_wmask_i,
    output b_req_i, b_we_i, b_addr_i, b_wdata_i, b_wmask_i,
    output sram_rdata_i,
    input  a_rdata_o, b_gnt_o, b_rvalid_o, b_rdata_o,
    input  sram_csb_o, sram_web_o, sram_addr_o, sram_wdata_o, sram_wmask_o,
    input  init_done_o
  );
endinterface

// File: rtl/dmem_sram_arbiter.sv
// dmem_sram_arbiter: single-port SRAM shared by a never-stalled core port and a request/grant programmer port
module dmem_sram_arbiter #(
  parameter int AddrW        = 13,
  parameter int DataW        = 32,
  parameter bit ClearOnReset = 1'b1
) (
  input logic                clk_i,
  input logic                rst_ni,
  dmem_sram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_RESET, S_CLEAR, S_IDLE} state_e;
  state_e           state_q, state_d;
  logic [AddrW:0]   cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             pend_q, pend_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [DataW-1:0] wdata_q, wdata_d;
  logic [3:0]       wmask_q, wmask_d;
  logic [DataW-1:0] rdata_q, rdata_d;
  logic             csb, web, gnt;
  // Sequencing of the clear pass and steering of the macro port; idle fields hold their last value
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    csb     = 1'b1;
    web     = 1'b1;
    gnt     = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    case (state_q)
      S_RESET: state_d = ClearOnReset ? S_CLEAR : S_IDLE;
      S_CLEAR: begin
        csb     = 1'b0;
        web     = 1'b0;
        addr_d  = cnt_q[AddrW-1:0];
        wdata_d = '0;
        wmask_d = 4'hF;
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_d[AddrW] ? S_IDLE : S_CLEAR;
      end
      S_IDLE: begin
        if (!bus.a_csb_i) begin
          csb     = 1'b0;
          web     = bus.a_we_i;
          addr_d  = bus.a_addr_i;
          wdata_d = bus.a_wdata_i;
          wmask_d = bus.a_wmask_i;
        end else if (bus.b_req_i) begin
          gnt     = 1'b1;
          csb     = 1'b0;
          web     = ~bus.b_we_i;
          addr_d  = bus.b_addr_i;
          wdata_d = bus.b_wdata_i;
          wmask_d = bus.b_wmask_i;
        end
      end
      default: state_d = S_RESET;
    endcase
    done_d  = done_q | (state_d == S_IDLE);
    pend_d  = gnt & ~bus.b_we_i;
    rdata_d = pend_q ? bus.sram_rdata_i : rdata_q;
  end
  // State, clear counter, held macro fields and programmer read tracking
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.sram_csb_o   = csb;
  assign bus.sram_web_o   = web;
  assign bus.sram_addr_o  = addr_d;
  assign bus.sram_wdata_o = wdata_d;
  assign bus.sram_wmask_o = wmask_d;
  assign bus.b_gnt_o      = gnt;
  assign bus.b_rvalid_o   = pend_q;
  assign bus.b_rdata_o    = rdata_d;
  assign bus.a_rdata_o    = (state_q == S_IDLE) ? bus.sram_rdata_i : '0;
  assign bus.init_done_o  = done_q;
endmodule

// File: tb/tb_dmem_sram_arbiter.sv
// tb_dmem_sram_arbiter: directed and randomized checks of the SRAM arbiter against a memory-level model
module tb_dmem_sram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n, rst_s;
  int          tests = 0, fails = 0;
  logic [31:0] mem [64];
  logic        seeded = 1'b0;
  logic [31:0] ref_mem [64];
  logic        exp_rv, exp_av, hold_b, a_act, e_gnt;
  logic [31:0] exp_bd, last_bd, exp_ar, v;
  logic [5:0]  last_addr, exp_addr;

  always #5 clk = ~clk;

  dmem_sram_arbiter_if #(.AddrW(6), .DataW(32)) bm ();
  dmem_sram_arbiter_if #(.AddrW(4), .DataW(32)) bs ();

  dmem_sram_arbiter #(.AddrW(6), .DataW(32), .ClearOnReset(1'b1)) u_main (
    .clk_i(clk), .rst_ni(rst_n), .bus(bm.slave));
  dmem_sram_arbiter #(.AddrW(4), .DataW(32), .ClearOnReset(1'b1)) u_small (
    .clk_i(clk), .rst_ni(rst_s), .bus(bs.slave));

  // SRAM macro model: masked writes, read data one cycle after a read; seeded with non-zero junk
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hBAD0_0000 | 32'(i + 1);
      seeded = 1'b1;
    end
    if (!bm.sram_csb_o) begin
      if (!bm.sram_web_o) begin
        for (int j = 0; j < 4; j++) if (bm.sram_wmask_o[j]) mem[bm.sram_addr_o][8*j +: 8] = bm.sram_wdata_o[8*j +: 8];
      end else bm.sram_rdata_i <= mem[bm.sram_addr_o];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int j = 0; j < 4; j++) if (m[j]) r[8*j +: 8] = wd[8*j +: 8];
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; rst_s = 1'b0;
    bm.a_csb_i = 1'b1; bm.a_we_i = 1'b1; bm.a_addr_i = '0; bm.a_wdata_i = '0; bm.a_wmask_i = '0;
    bm.b_req_i = 1'b0; bm.b_we_i = 1'b0; bm.b_addr_i = '0; bm.b_wdata_i = '0; bm.b_wmask_i = '0;
    bs.a_csb_i = 1'b1; bs.a_we_i = 1'b1; bs.a_addr_i = '0; bs.a_wdata_i = '0; bs.a_wmask_i = '0;
    bs.b_req_i = 1'b1; bs.b_we_i = 1'b0; bs.b_addr_i = '0; bs.b_wdata_i = '0; bs.b_wmask_i = '0;
    bs.sram_rdata_i = 32'hA5A5_A5A5;
    repeat (3) tick();
    chk("rst_csb", 32'(bm.sram_csb_o), 1);
    chk("rst_web", 32'(bm.sram_web_o), 1);
    chk("rst_gnt", 32'(bm.b_gnt_o), 0);
    chk("rst_rvalid", 32'(bm.b_rvalid_o), 0);
    chk("rst_brdata", bm.b_rdata_o, 0);
    chk("rst_addr", 32'(bm.sram_addr_o), 0);
    chk("rst_wdata", bm.sram_wdata_o, 0);
    chk("rst_wmask", 32'(bm.sram_wmask_o), 0);
    chk("rst_done", 32'(bm.init_done_o), 0);
    chk("rst_small_gnt", 32'(bs.b_gnt_o), 0);
    // clear pass on the 16-word instance while port B keeps requesting
    rst_n = 1'b1; rst_s = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("clr_csb", 32'(bs.sram_csb_o), 0);
      chk("clr_web", 32'(bs.sram_web_o), 0);
      chk("clr_addr", 32'(bs.sram_addr_o), 32'(i));
      chk("clr_wdata", bs.sram_wdata_o, 0);
      chk("clr_wmask", 32'(bs.sram_wmask_o), 32'hF);
      chk("clr_gnt", 32'(bs.b_gnt_o), 0);
      chk("clr_done", 32'(bs.init_done_o), 0);
      chk("clr_ardata", bs.a_rdata_o, 0);
      tick();
    end
    chk("clr_done_rise", 32'(bs.init_done_o), 1);
    chk("clr_first_gnt", 32'(bs.b_gnt_o), 1);
    chk("idle_ardata", bs.a_rdata_o, 32'hA5A5_A5A5);
    bs.b_req_i = 1'b0;
    // reset in the middle of a clear restarts it from address 0
    rst_s = 1'b0; tick();
    chk("rerst_done", 32'(bs.init_done_o), 0);
    rst_s = 1'b1; tick();
    for (int i = 0; i < 7; i++) tick();
    chk("mid_addr7", 32'(bs.sram_addr_o), 7);
    rst_s = 1'b0; tick();
    chk("mid_rst_csb", 32'(bs.sram_csb_o), 1);
    chk("mid_rst_addr", 32'(bs.sram_addr_o), 0);
    rst_s = 1'b1; tick();
    for (int i = 0; i < 16; i++) begin
      chk("re_addr", 32'(bs.sram_addr_o), 32'(i));
      chk("re_done", 32'(bs.init_done_o), 0);
      tick();
    end
    chk("re_done_end", 32'(bs.init_done_o), 1);
    // main instance still clearing: a pending port B request must not be granted
    chk("main_clearing", 32'(bm.init_done_o), 0);
    bm.b_req_i = 1'b1; bm.b_we_i = 1'b0; bm.b_addr_i = 6'd5;
    for (int i = 0; i < 100 && bm.init_done_o !== 1'b1; i++) begin
      chk("main_nognt", 32'(bm.b_gnt_o), 0);
      tick();
    end
    chk("main_done", 32'(bm.init_done_o), 1);
    chk("main_first_gnt", 32'(bm.b_gnt_o), 1);
    bm.b_req_i = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    tick();
    // core pass-through write then read
    bm.a_csb_i = 1'b0; bm.a_we_i = 1'b0; bm.a_addr_i = 6'h10; bm.a_wdata_i = 32'hDEAD_BEEF; bm.a_wmask_i = 4'hF;
    #1;
    chk("core_wr_csb", 32'(bm.sram_csb_o), 0);
    chk("core_wr_web", 32'(bm.sram_web_o), 0);
    chk("core_wr_addr", 32'(bm.sram_addr_o), 32'h10);
    chk("core_wr_data", bm.sram_wdata_o, 32'hDEAD_BEEF);
    ref_mem[6'h10] = 32'hDEAD_BEEF;
    tick();
    bm.a_we_i = 1'b1;
    #1;
    chk("core_rd_web", 32'(bm.sram_web_o), 1);
    chk("core_rd_addr", 32'(bm.sram_addr_o), 32'h10);
    tick();
    bm.a_csb_i = 1'b1;
    #1;
    chk("core_rdata", bm.a_rdata_o, 32'hDEAD_BEEF);
    chk("hold_csb", 32'(bm.sram_csb_o), 1);
    chk("hold_addr", 32'(bm.sram_addr_o), 32'h10);
    chk("no_rvalid_core", 32'(bm.b_rvalid_o), 0);
    // collision: core owns three cycles, port B holds its read of 0x20
    v = $urandom;
    bm.a_csb_i = 1'b0; bm.a_we_i = 1'b0; bm.a_addr_i = 6'h20; bm.a_wdata_i = v; bm.a_wmask_i = 4'hF;
    ref_mem[6'h20] = v;
    tick();
    bm.a_we_i = 1'b1; bm.a_addr_i = 6'h10;
    bm.b_req_i = 1'b1; bm.b_we_i = 1'b0; bm.b_addr_i = 6'h20;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("coll_gnt", 32'(bm.b_gnt_o), 0);
      chk("coll_addr", 32'(bm.sram_addr_o), 32'h10);
      tick();
    end
    bm.a_csb_i = 1'b1;
    #1;
    chk("coll_gnt_late", 32'(bm.b_gnt_o), 1);
    chk("coll_addr_b", 32'(bm.sram_addr_o), 32'h20);
    chk("coll_web_b", 32'(bm.sram_web_o), 1);
    tick();
    bm.b_req_i = 1'b0; bm.a_csb_i = 1'b0; bm.a_addr_i = 6'h10;
    #1;
    chk("coll_rvalid", 32'(bm.b_rvalid_o), 1);
    chk("coll_brdata", bm.b_rdata_o, v);
    tick();
    bm.a_csb_i = 1'b1;
    #1;
    chk("coll_rvalid_off", 32'(bm.b_rvalid_o), 0);
    chk("coll_brdata_hold", bm.b_rdata_o, v);
    chk("coll_core_rdata", bm.a_rdata_o, 32'hDEAD_BEEF);
    // streaming: four writes then four back-to-back reads
    for (int k = 0; k < 4; k++) begin
      bm.b_req_i = 1'b1; bm.b_we_i = 1'b1; bm.b_addr_i = 6'(k); bm.b_wdata_i = 32'(k + 1); bm.b_wmask_i = 4'hF;
      #1;
      chk("strm_wr_gnt", 32'(bm.b_gnt_o), 1);
      chk("strm_wr_web", 32'(bm.sram_web_o), 0);
      ref_mem[k] = 32'(k + 1);
      tick();
      chk("strm_wr_norv", 32'(bm.b_rvalid_o), 0);
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        chk("strm_rvalid", 32'(bm.b_rvalid_o), 1);
        chk("strm_rdata", bm.b_rdata_o, ref_mem[k-1]);
      end
      if (k < 4) begin
        bm.b_we_i = 1'b0; bm.b_addr_i = 6'(k);
        #1;
        chk("strm_rd_gnt", 32'(bm.b_gnt_o), 1);
      end else bm.b_req_i = 1'b0;
      tick();
    end
    chk("strm_rv_end", 32'(bm.b_rvalid_o), 0);
    // byte-masked port B write, read back through the core
    bm.b_req_i = 1'b1; bm.b_we_i = 1'b1; bm.b_addr_i = 6'h30; bm.b_wdata_i = 32'hAABB_CCDD; bm.b_wmask_i = 4'h5;
    #1;
    chk("mask_gnt", 32'(bm.b_gnt_o), 1);
    ref_mem[6'h30] = merge(ref_mem[6'h30], 32'hAABB_CCDD, 4'h5);
    tick();
    bm.b_req_i = 1'b0; bm.a_csb_i = 1'b0; bm.a_we_i = 1'b1; bm.a_addr_i = 6'h30;
    tick();
    bm.a_csb_i = 1'b1;
    #1;
    chk("mask_rdata", bm.a_rdata_o, 32'h00BB_00DD);
    // randomized traffic against the memory-level model
    exp_rv = 1'b0; exp_av = 1'b0; hold_b = 1'b0; last_bd = ref_mem[3]; last_addr = 6'h30; exp_bd = '0; exp_ar = '0;
    for (int c = 0; c < 300; c++) begin
      chk("rnd_rvalid", 32'(bm.b_rvalid_o), 32'(exp_rv));
      if (exp_rv) last_bd = exp_bd;
      chk("rnd_brdata", bm.b_rdata_o, last_bd);
      if (exp_av) chk("rnd_ardata", bm.a_rdata_o, exp_ar);
      a_act = 1'($urandom_range(0, 1));
      bm.a_csb_i = ~a_act; bm.a_we_i = 1'($urandom); bm.a_addr_i = 6'($urandom);
      bm.a_wdata_i = $urandom; bm.a_wmask_i = 4'($urandom);
      if (!hold_b) begin
        bm.b_req_i = ($urandom_range(0, 9) < 6); bm.b_we_i = 1'($urandom); bm.b_addr_i = 6'($urandom);
        bm.b_wdata_i = $urandom; bm.b_wmask_i = 4'($urandom);
      end
      #1;
      e_gnt = bm.b_req_i && !a_act;
      exp_addr = a_act ? bm.a_addr_i : (e_gnt ? bm.b_addr_i : last_addr);
      chk("rnd_gnt", 32'(bm.b_gnt_o), 32'(e_gnt));
      chk("rnd_csb", 32'(bm.sram_csb_o), 32'(!(a_act || e_gnt)));
      chk("rnd_addr", 32'(bm.sram_addr_o), 32'(exp_addr));
      exp_rv = 1'b0; exp_av = 1'b0;
      if (a_act) begin
        if (!bm.a_we_i) ref_mem[bm.a_addr_i] = merge(ref_mem[bm.a_addr_i], bm.a_wdata_i, bm.a_wmask_i);
        else begin exp_av = 1'b1; exp_ar = ref_mem[bm.a_addr_i]; end
      end else if (e_gnt) begin
        if (bm.b_we_i) ref_mem[bm.b_addr_i] = merge(ref_mem[bm.b_addr_i], bm.b_wdata_i, bm.b_wmask_i);
        else begin exp_rv = 1'b1; exp_bd = ref_mem[bm.b_addr_i]; end
      end
      last_addr = exp_addr;
      hold_b = bm.b_req_i && !e_gnt;
      tick();
    end
    bm.a_csb_i = 1'b1; bm.b_req_i = 1'b0;
    tick();
    // reset while a port B read is outstanding drops it
    bm.b_req_i = 1'b1; bm.b_we_i = 1'b0; bm.b_addr_i = 6'h10;
    #1;
    chk("drop_gnt", 32'(bm.b_gnt_o), 1);
    rst_n = 1'b0;
    tick();
    bm.b_req_i = 1'b0;
    chk("drop_rvalid_rst", 32'(bm.b_rvalid_o), 0);
    chk("drop_brdata_rst", bm.b_rdata_o, 0);
    rst_n = 1'b1;
    tick();
    chk("drop_rvalid_after", 32'(bm.b_rvalid_o), 0);
    chk("drop_done", 32'(bm.init_done_o), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
